// File: rtl/overlay_pkg.sv
// Shared constants and the 5x7 glyph table used by the text overlay.
package overlay_pkg;

  localparam int unsigned CODE_W     = 5;
  localparam int unsigned CELL_W     = 6;
  localparam int unsigned CELL_H     = 8;
  localparam int unsigned GLYPH_ROWS = 7;
  localparam logic [CODE_W-1:0] BLANK = 5'h1F;

  // Whole glyph, row 0 in the top five bits, MSB of each row = leftmost pixel.
  function automatic logic [34:0] glyph(input logic [CODE_W-1:0] code);
    logic [34:0] g;
    case (code)
      5'h00: g = 35'b01110_10001_10011_10101_11001_10001_01110;
      5'h01: g = 35'b00100_01100_00100_00100_00100_00100_01110;
      5'h02: g = 35'b01110_10001_00001_00010_00100_01000_11111;
      5'h03: g = 35'b11111_00010_00100_00010_00001_10001_01110;
      5'h04: g = 35'b00010_00110_01010_10010_11111_00010_00010;
      5'h05: g = 35'b11111_10000_11110_00001_00001_10001_01110;
      5'h06: g = 35'b00110_01000_10000_11110_10001_10001_01110;
      5'h07: g = 35'b11111_00001_00010_00100_01000_01000_01000;
      5'h08: g = 35'b01110_10001_10001_01110_10001_10001_01110;
      5'h09: g = 35'b01110_10001_10001_01111_00001_00010_01100;
      5'h0A: g = 35'b01110_10001_10001_11111_10001_10001_10001;
      5'h0B: g = 35'b11110_10001_10001_11110_10001_10001_11110;
      5'h0C: g = 35'b01110_10001_10000_10000_10000_10001_01110;
      5'h0D: g = 35'b11100_10010_10001_10001_10001_10010_11100;
      5'h0E: g = 35'b11111_10000_10000_11110_10000_10000_11111;
      5'h0F: g = 35'b11111_10000_10000_11110_10000_10000_10000;
      5'h10: g = 35'b01110_10001_10000_10111_10001_10001_01111; // G
      5'h11: g = 35'b10001_10001_10001_11111_10001_10001_10001; // H
      5'h12: g = 35'b01110_00100_00100_00100_00100_00100_01110; // I
      5'h13: g = 35'b00111_00010_00010_00010_00010_10010_01100; // J
      5'h14: g = 35'b10001_10010_10100_11000_10100_10010_10001; // K
      5'h15: g = 35'b10000_10000_10000_10000_10000_10000_11111; // L
      5'h16: g = 35'b10001_11011_10101_10101_10001_10001_10001; // M
      5'h17: g = 35'b10001_10001_11001_10101_10011_10001_10001; // N
      5'h18: g = 35'b01110_10001_10001_10001_10001_10001_01110; // O
      5'h19: g = 35'b11110_10001_10001_11110_10000_10000_10000; // P
      5'h1A: g = 35'b11110_10001_10001_11110_10100_10010_10001; // R
      5'h1B: g = 35'b01111_10000_10000_01110_00001_00001_11110; // S
      5'h1C: g = 35'b11111_00100_00100_00100_00100_00100_00100; // T
      5'h1D: g = 35'b10001_10001_10001_10001_10001_10001_01110; // U
      5'h1E: g = 35'b10001_10001_01010_00100_01010_10001_10001; // X
      default: g = '0;
    endcase
    return g;
  endfunction

  function automatic logic [4:0] font_row(input logic [CODE_W-1:0] code,
                                          input logic [2:0] row);
    if (32'(row) >= GLYPH_ROWS) return 5'b0;
    return 5'(glyph(code) >> (5 * (6 - 32'(row))));
  endfunction

endpackage

// File: rtl/overlay_font.sv
// Registered font-row lookup; isolated so a block-RAM font can drop in.
module overlay_font
  import overlay_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic [CODE_W-1:0] code,
  input  logic [2:0]        row,
  output logic [4:0]        bits
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  bits <= '0;
    else if (ce)   bits <= font_row(code, row);
  end

endmodule

// File: rtl/text_overlay.sv
// On-screen debug text overlay: snapshots a character grid at vblank and
// merges it into the pixel stream through a 3-stage ce_pix pipeline.
module text_overlay
  import overlay_pkg::*;
#(
  parameter int unsigned LINES = 2,
  parameter int unsigned CHARS = 32,
  parameter int unsigned CW    = 10,
  parameter int unsigned X0    = 16,
  parameter int unsigned Y0    = 16,
  parameter int unsigned SCALE = 0,
  parameter logic [3:0]  FG    = 4'hF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ce_pix,
  input  logic                          ena,
  input  logic [CW-1:0]                 hcount,
  input  logic [CW-1:0]                 vcount,
  input  logic                          vblank,
  input  logic [LINES*CHARS*CODE_W-1:0] text_in,
  input  logic [3:0]                    i_r,
  input  logic [3:0]                    i_g,
  input  logic [3:0]                    i_b,
  output logic [3:0]                    o_r,
  output logic [3:0]                    o_g,
  output logic [3:0]                    o_b,
  output logic                          o_box
);

  localparam int unsigned CHAR_W = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam int unsigned LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned XW     = CW + 1;
  localparam int unsigned BOX_W  = (CHARS * CELL_W) << SCALE;
  localparam int unsigned BOX_H  = (LINES * CELL_H) << SCALE;

  logic [CODE_W-1:0] snap [LINES][CHARS];
  logic              vblank_q;

  // Snapshot loads only on a sampled vblank rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q <= 1'b1;
      for (int l = 0; l < LINES; l++)
        for (int c = 0; c < CHARS; c++)
          snap[l][c] <= BLANK;
    end else if (ce_pix) begin
      vblank_q <= vblank;
      if (vblank && !vblank_q)
        for (int l = 0; l < LINES; l++)
          for (int c = 0; c < CHARS; c++)
            snap[l][c] <= text_in[(l*CHARS + c)*CODE_W +: CODE_W];
    end
  end

  logic [31:0]       h32, v32;
  logic [XW-1:0]     dx, dy;
  logic              in_box_c;
  logic [CHAR_W-1:0] char_c;
  logic [LINE_W-1:0] line_c;
  logic [2:0]        col_c, row_c;

  // Geometry is compared at full width so a box past 2^CW cannot wrap.
  always_comb begin
    h32      = 32'(hcount);
    v32      = 32'(vcount);
    in_box_c = ena && (h32 >= X0) && (h32 < X0 + BOX_W)
                   && (v32 >= Y0) && (v32 < Y0 + BOX_H);
    dx       = XW'((h32 - X0) >> SCALE);
    dy       = XW'((v32 - Y0) >> SCALE);
    char_c   = '0;
    for (int unsigned c = 1; c < CHARS; c++)
      if (32'(dx) >= 32'(c * CELL_W)) char_c = CHAR_W'(c);
    col_c    = 3'(32'(dx) - 32'(char_c) * CELL_W);
    line_c   = LINE_W'(dy >> 3);
    row_c    = dy[2:0];
  end

  logic              s1_box;
  logic [CHAR_W-1:0] s1_char;
  logic [LINE_W-1:0] s1_line;
  logic [2:0]        s1_col, s1_row;
  logic [3:0]        s1_r, s1_g, s1_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_box  <= 1'b0;
      s1_char <= '0;
      s1_line <= '0;
      s1_col  <= '0;
      s1_row  <= '0;
      s1_r    <= '0;
      s1_g    <= '0;
      s1_b    <= '0;
    end else if (ce_pix) begin
      s1_box  <= in_box_c;
      s1_char <= char_c;
      s1_line <= line_c;
      s1_col  <= col_c;
      s1_row  <= row_c;
      s1_r    <= i_r;
      s1_g    <= i_g;
      s1_b    <= i_b;
    end
  end

  logic [CODE_W-1:0] code_c;
  logic [4:0]        font_bits;
  logic              s2_box;
  logic [2:0]        s2_col;
  logic [3:0]        s2_r, s2_g, s2_b;

  assign code_c = snap[s1_line][s1_char];

  overlay_font u_font (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce_pix),
    .code    (code_c),
    .row     (s1_row),
    .bits    (font_bits)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_box <= 1'b0;
      s2_col <= '0;
      s2_r   <= '0;
      s2_g   <= '0;
      s2_b   <= '0;
    end else if (ce_pix) begin
      s2_box <= s1_box;
      s2_col <= s1_col;
      s2_r   <= s1_r;
      s2_g   <= s1_g;
      s2_b   <= s1_b;
    end
  end

  logic [4:0] shifted;
  logic       lit;

  // Column 5 shifts every glyph bit out, so the spacer column is never lit.
  always_comb begin
    shifted = font_bits << s2_col;
    lit     = s2_box && shifted[4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_r   <= '0;
      o_g   <= '0;
      o_b   <= '0;
      o_box <= 1'b0;
    end else if (ce_pix) begin
      o_box <= s2_box;
      if (lit) begin
        o_r <= FG;
        o_g <= FG;
        o_b <= FG;
      end else if (s2_box) begin
        o_r <= s2_r >> 1;
        o_g <= s2_g >> 1;
        o_b <= s2_b >> 1;
      end else begin
        o_r <= s2_r;
        o_g <= s2_g;
        o_b <= s2_b;
      end
    end
  end

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: three configurations driven in lockstep,
// outputs compared against a bench-side pixel model three ce_pix cycles later.
module tb_text_overlay;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, ce_pix, ena, vblank;
  logic [9:0]   h0, v0;
  logic [8:0]   h2, v2;
  logic [319:0] text0, text1;
  logic [39:0]  text2;
  logic [3:0]   i_r, i_g, i_b;
  logic [3:0]   r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic         box0, box1, box2;

  text_overlay #(.LINES(2), .CHARS(32), .CW(10), .X0(16), .Y0(16), .SCALE(0), .FG(4'hF)) u0 (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .ena(ena), .hcount(h0), .vcount(v0),
    .vblank(vblank), .text_in(text0), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_r(r0), .o_g(g0), .o_b(b0), .o_box(box0));

  text_overlay #(.LINES(2), .CHARS(32), .CW(10), .X0(16), .Y0(16), .SCALE(1), .FG(4'hF)) u1 (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .ena(ena), .hcount(h0), .vcount(v0),
    .vblank(vblank), .text_in(text1), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_r(r1), .o_g(g1), .o_b(b1), .o_box(box1));

  text_overlay #(.LINES(2), .CHARS(4), .CW(9), .X0(500), .Y0(16), .SCALE(0), .FG(4'hF)) u2 (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .ena(ena), .hcount(h2), .vcount(v2),
    .vblank(vblank), .text_in(text2), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .o_r(r2), .o_g(g2), .o_b(b2), .o_box(box2));

  int checks = 0;
  int errors = 0;

  logic [4:0]  ms [3][64];
  logic [12:0] q0[$], q1[$], q2[$];
  int          qh[$], qv[$], qm[$];
  logic [12:0] last_e0;

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic glyph_bit(input logic [4:0] code, input int row, input int col);
    logic [34:0] g;
    case (code)
      5'h08:   g = 35'b01110_10001_10001_01110_10001_10001_01110;
      5'h0A:   g = 35'b01110_10001_10001_11111_10001_10001_10001;
      5'h0F:   g = 35'b11111_10000_10000_11110_10000_10000_10000;
      default: g = '0;
    endcase
    return g[34 - row*5 - col];
  endfunction

  function automatic logic [12:0] model(input int d, input int h, input int v,
                                        input logic [3:0] r, input logic [3:0] g,
                                        input logic [3:0] b, input logic en);
    int x0, sc, ch, w, hg, dx, dy;
    logic lit;
    case (d)
      0:       begin x0 = 16;  sc = 0; ch = 32; end
      1:       begin x0 = 16;  sc = 1; ch = 32; end
      default: begin x0 = 500; sc = 0; ch = 4;  end
    endcase
    w  = (ch * 6) << sc;
    hg = 16 << sc;
    if (!(en && h >= x0 && h < x0 + w && v >= 16 && v < 16 + hg))
      return {1'b0, r, g, b};
    dx  = (h - x0) >> sc;
    dy  = (v - 16) >> sc;
    lit = (dx % 6 < 5) && (dy % 8 < 7) &&
          glyph_bit(ms[d][(dy / 8) * ch + dx / 6], dy % 8, dx % 6);
    if (lit) return {1'b1, 4'hF, 4'hF, 4'hF};
    return {1'b1, r >> 1, g >> 1, b >> 1};
  endfunction

  task automatic load_model();
    for (int c = 0; c < 64; c++) begin
      ms[0][c] = text0[c*5 +: 5];
      ms[1][c] = text1[c*5 +: 5];
    end
    for (int c = 0; c < 8; c++) ms[2][c] = text2[c*5 +: 5];
  endtask

  // One ce_pix pixel; compares the pixel presented two ticks earlier.
  task automatic tick(input int h, input int v, input logic [3:0] rgb, input int mask);
    logic [12:0] e0, e1, e2;
    int hh, vv, m;
    h0 = 10'(h); v0 = 10'(v); h2 = 9'(h); v2 = 9'(v);
    i_r = rgb; i_g = ~rgb; i_b = rgb ^ 4'h6;
    q0.push_back(model(0, h % 1024, v % 1024, i_r, i_g, i_b, ena));
    q1.push_back(model(1, h % 1024, v % 1024, i_r, i_g, i_b, ena));
    q2.push_back(model(2, h % 512, v % 512, i_r, i_g, i_b, ena));
    qh.push_back(h); qv.push_back(v); qm.push_back(mask);
    ce_pix = 1'b1;
    @(posedge clk); #1;
    if (q0.size() == 3) begin
      e0 = q0.pop_front(); e1 = q1.pop_front(); e2 = q2.pop_front();
      hh = qh.pop_front(); vv = qv.pop_front(); m = qm.pop_front();
      last_e0 = e0;
      if ((m & 1) != 0) chk($sformatf("px0 h=%0d v=%0d", hh, vv), {box0, r0, g0, b0}, e0);
      if ((m & 2) != 0) chk($sformatf("px1 h=%0d v=%0d", hh, vv), {box1, r1, g1, b1}, e1);
      if ((m & 4) != 0) chk($sformatf("px2 h=%0d v=%0d", hh % 512, vv % 512), {box2, r2, g2, b2}, e2);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) tick(1000, 1000, 4'h8, 0);
  endtask

  task automatic vb_edge();
    vblank = 1'b0; tick(1000, 1000, 4'h8, 0);
    vblank = 1'b1; tick(1000, 1000, 4'h8, 0);
    load_model();
    vblank = 1'b0; tick(1000, 1000, 4'h8, 0);
  endtask

  initial begin
    reset_n = 1'b0; ce_pix = 1'b0; ena = 1'b1; vblank = 1'b1;
    h0 = '0; v0 = '0; h2 = '0; v2 = '0;
    i_r = 4'h8; i_g = 4'h8; i_b = 4'h8;
    text0 = {64{5'h1F}}; text0[4:0] = 5'h08;
    text1 = {64{5'h1F}}; text1[63*5 +: 5] = 5'h0F;
    text2 = {8{5'h1F}};  text2[4:0] = 5'h08; text2[9:5] = 5'h0A;
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 64; c++) ms[d][c] = 5'h1F;

    // Reset with ce_pix toggling and box pixels presented.
    for (int i = 0; i < 6; i++) begin
      ce_pix = (i % 2) == 1;
      h0 = 10'(16 + i); v0 = 10'd16; h2 = 9'(500 + i); v2 = 9'd16;
      @(posedge clk); #1;
      chk("reset0", {box0, r0, g0, b0}, 13'h0);
      chk("reset2", {box2, r2, g2, b2}, 13'h0);
    end

    // Release while vblank is high: the snapshot must stay blank.
    reset_n = 1'b1;
    for (int h = 12; h < 25; h++) tick(h, 16, 4'h8, 1);
    vblank = 1'b0;
    foreach (qh[i]) ;
    for (int h = 12; h < 25; h++) tick(h, 18, 4'h8, 1);
    for (int h = 12; h < 25; h++) tick(h, 23, 4'h8, 1);
    for (int h = 205; h < 211; h++) tick(h, 31, 4'h8, 1);
    for (int h = 205; h < 211; h++) tick(h, 32, 4'h8, 1);
    flush();

    // Digit '8' at cell 0 after a vblank rising edge.
    vb_edge();
    for (int v = 15; v < 25; v++)
      for (int h = 14; h < 24; h++) tick(h, v, 4'(h + v), 1);
    for (int h = 206; h < 210; h++) tick(h, 20, 4'h9, 1);
    flush();

    // Mid-frame text change is invisible until the next vblank edge.
    text0[4:0] = 5'h0A;
    for (int h = 15; h < 23; h++) tick(h, 19, 4'h6, 1);
    flush();
    vb_edge();
    for (int h = 15; h < 23; h++) tick(h, 19, 4'h6, 1);

    // ena dropped for three pixels mid-line.
    for (int h = 14; h < 25; h++) begin
      ena = !(h >= 18 && h < 21);
      tick(h, 16, 4'hA, 1);
    end
    ena = 1'b1;

    // Five-clock stall in the middle of a line.
    for (int h = 14; h < 18; h++) tick(h, 20, 4'hB, 1);
    ce_pix = 1'b0;
    h0 = 10'd19; v0 = 10'd17; i_r = 4'hC; i_g = 4'h1; i_b = 4'h2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d", i), {box0, r0, g0, b0}, last_e0);
    end
    for (int h = 18; h < 24; h++) tick(h, 20, 4'hB, 1);
    flush();

    // Scaled instance: 'F' in the last cell of line 1, edges of the box.
    for (int v = 30; v < 50; v++)
      for (int h = 386; h < 402; h++) tick(h, v, 4'(h), 2);
    flush();

    // Narrow CW: box near the top of the counter range must not wrap.
    for (int v = 15; v < 25; v++)
      for (int h = 498; h < 524; h++) tick(h, v, 4'(v), 4);
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
